// File: rtl/encode_mul_pkg.sv
// Shared constants and helpers for the encoder multiplier arbiter.
//   A_WIDTH / B_WIDTH / P_WIDTH : default operand and product widths
//   N_REQ_MAX                   : largest supported requester count
//   clog2()                     : tag width for a given requester count
//   tag_t                       : tag wide enough for N_REQ_MAX requesters
package encode_mul_pkg;

  localparam int unsigned A_WIDTH   = 40;
  localparam int unsigned B_WIDTH   = 25;
  localparam int unsigned P_WIDTH   = 64;
  localparam int unsigned N_REQ_MAX = 8;

  // Minimum result is 1 so a tag is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned TAG_W_MAX = clog2(N_REQ_MAX);

  typedef logic [TAG_W_MAX-1:0] tag_t;

endpackage

// File: rtl/encode_mul_40s_25ns_64_2_1.sv
// Pipelined multiplier: signed din0 x unsigned din1 -> dout, NUM_STAGE-1
// register stages, all gated by ce. Data registers are not reset.
//   clk  : rising-edge clock
//   ce   : clock enable; all stages hold while low
//   din0 : signed operand
//   din1 : unsigned operand
//   dout : low dout_WIDTH bits of the product
module encode_mul_40s_25ns_64_2_1 #(
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned din0_WIDTH = 40,
  parameter int unsigned din1_WIDTH = 25,
  parameter int unsigned dout_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Extending both operands to the product width first gives the correctly
  // truncated low bits without keeping any unused upper product bits.
  logic signed [dout_WIDTH-1:0] w_a_ext;
  logic signed [dout_WIDTH-1:0] w_b_ext;
  logic signed [dout_WIDTH-1:0] w_prod;

  assign w_a_ext = dout_WIDTH'($signed(din0));
  assign w_b_ext = dout_WIDTH'(din1);
  assign w_prod  = w_a_ext * w_b_ext;

  logic [dout_WIDTH-1:0] r_pipe [NUM_STAGE-1];

  always_ff @(posedge clk) begin
    if (ce) begin
      r_pipe[0] <= w_prod;
      for (int unsigned s = 1; s < NUM_STAGE - 1; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign dout = r_pipe[NUM_STAGE-2];

endmodule

// File: rtl/encode_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier between N_REQ requesters.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   req_valid : per-requester request valid
//   req_ready : per-requester accept (one-hot or zero)
//   req_a     : packed signed operands, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b     : packed unsigned operands, requester i at [i*B_WIDTH +: B_WIDTH]
//   rsp_valid : product available
//   rsp_ready : consumer accepts product
//   rsp_id    : requester index owning rsp_data
//   rsp_data  : signed product
//   busy      : stage holds an unconsumed product (same as rsp_valid)
module encode_mul_arbiter
  import encode_mul_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = encode_mul_pkg::clog2(N_REQ),
  parameter int unsigned A_WIDTH = encode_mul_pkg::A_WIDTH,
  parameter int unsigned B_WIDTH = encode_mul_pkg::B_WIDTH,
  parameter int unsigned P_WIDTH = encode_mul_pkg::P_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]   req_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [P_WIDTH-1:0]         rsp_data,
  output logic                       busy
);

  logic              r_s1_valid;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_rsp_id;

  logic              w_ce;
  logic              w_any;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_cand;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [A_WIDTH-1:0] w_a;
  logic [B_WIDTH-1:0] w_b;

  // The stage may advance when empty or when its product is being drained.
  assign w_ce = !r_s1_valid || rsp_ready;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_any     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any            = 1'b1;
        w_gnt_idx        = w_cand;
        w_grant[w_cand]  = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Held low during reset so nothing looks accepted while the stage is cleared.
  assign req_ready = w_grant & {N_REQ{w_ce & reset}};

  assign w_a = req_a[w_gnt_idx*A_WIDTH +: A_WIDTH];
  assign w_b = req_b[w_gnt_idx*B_WIDTH +: B_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_rsp_id   <= '0;
      r_ptr      <= '0;
    end else if (w_ce) begin
      r_s1_valid <= w_any;
      if (w_any) begin
        r_rsp_id <= w_gnt_idx;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  encode_mul_40s_25ns_64_2_1 #(
    .NUM_STAGE  (2),
    .din0_WIDTH (A_WIDTH),
    .din1_WIDTH (B_WIDTH),
    .dout_WIDTH (P_WIDTH)
  ) u_mul (
    .clk  (clk),
    .ce   (w_ce),
    .din0 (w_a),
    .din1 (w_b),
    .dout (rsp_data)
  );

  assign rsp_valid = r_s1_valid;
  assign busy      = r_s1_valid;
  assign rsp_id    = r_rsp_id;

endmodule
